// File: rtl/seg_trace_decoder.sv
// Seven-segment trace decoder: turns sampled display codes of the 6-state digit
// counter back into digits, validates each step and recovers the driving input bit.
module seg_trace_decoder #(
  parameter int HIST_W = 8,
  parameter int ERR_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample,
  input  logic [6:0]        seg_in,
  output logic [2:0]        digit,
  output logic              locked,
  output logic              bit_valid,
  output logic              bit_out,
  output logic [HIST_W-1:0] bit_hist,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count
);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  // Returns {valid, digit}; segments are active-low, order {g,f,e,d,c,b,a}.
  function automatic logic [3:0] seg_decode(input logic [6:0] seg);
    logic [3:0] v;
    case (seg)
      7'b1000000: v = 4'b1000;
      7'b1111001: v = 4'b1001;
      7'b0100100: v = 4'b1010;
      7'b0110000: v = 4'b1011;
      7'b0011001: v = 4'b1100;
      7'b0010010: v = 4'b1101;
      default:    v = 4'b0000;
    endcase
    return v;
  endfunction

  function automatic logic [2:0] succ_in0(input logic [2:0] p);
    logic [2:0] s;
    if (p >= 3'd5) begin
      s = 3'd0;
    end else begin
      s = p + 3'd1;
    end
    return s;
  endfunction

  function automatic logic [2:0] succ_in1(input logic [2:0] p);
    logic [2:0] s;
    case (p)
      3'd0:    s = 3'd3;
      3'd1:    s = 3'd5;
      3'd2:    s = 3'd0;
      3'd3:    s = 3'd1;
      3'd4:    s = 3'd2;
      3'd5:    s = 3'd4;
      default: s = 3'd0;
    endcase
    return s;
  endfunction

  state_t            r_state;
  logic [2:0]        r_digit;
  logic              r_locked;
  logic              r_bit_valid;
  logic              r_bit_out;
  logic [HIST_W-1:0] r_bit_hist;
  logic              r_err_pulse;
  logic [ERR_W-1:0]  r_err_count;

  logic [3:0]        w_dec;
  logic              w_code_ok;
  logic [2:0]        w_d;
  logic [2:0]        w_succ0;
  logic [2:0]        w_succ1;
  logic [ERR_W-1:0]  w_err_next;

  // Decode the incoming code and precompute both legal successors of the held digit.
  always_comb begin
    w_dec     = seg_decode(seg_in);
    w_code_ok = w_dec[3];
    w_d       = w_dec[2:0];
    w_succ0   = succ_in0(r_digit);
    w_succ1   = succ_in1(r_digit);
    if (r_err_count == {ERR_W{1'b1}}) begin
      w_err_next = r_err_count;
    end else begin
      w_err_next = r_err_count + {{(ERR_W-1){1'b0}}, 1'b1};
    end
  end

  // Lock/step FSM with all outputs registered; pulses last one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_UNLOCKED;
      r_digit     <= 3'd0;
      r_locked    <= 1'b0;
      r_bit_valid <= 1'b0;
      r_bit_out   <= 1'b0;
      r_bit_hist  <= {HIST_W{1'b0}};
      r_err_pulse <= 1'b0;
      r_err_count <= {ERR_W{1'b0}};
    end else begin
      r_bit_valid <= 1'b0;
      r_err_pulse <= 1'b0;
      if (sample) begin
        case (r_state)
          ST_UNLOCKED: begin
            if (w_code_ok) begin
              r_digit  <= w_d;
              r_locked <= 1'b1;
              r_state  <= ST_LOCKED;
            end else begin
              r_err_pulse <= 1'b1;
              r_err_count <= w_err_next;
            end
          end
          ST_LOCKED: begin
            if (!w_code_ok) begin
              // Digit keeps its last good value so the display trace stays readable.
              r_err_pulse <= 1'b1;
              r_err_count <= w_err_next;
              r_locked    <= 1'b0;
              r_state     <= ST_UNLOCKED;
            end else if (w_d == w_succ0) begin
              r_bit_out   <= 1'b0;
              r_bit_valid <= 1'b1;
              r_bit_hist  <= {r_bit_hist[HIST_W-2:0], 1'b0};
              r_digit     <= w_d;
            end else if (w_d == w_succ1) begin
              r_bit_out   <= 1'b1;
              r_bit_valid <= 1'b1;
              r_bit_hist  <= {r_bit_hist[HIST_W-2:0], 1'b1};
              r_digit     <= w_d;
            end else begin
              r_err_pulse <= 1'b1;
              r_err_count <= w_err_next;
              r_digit     <= w_d;
            end
          end
          default: begin
            r_state  <= ST_UNLOCKED;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign digit     = r_digit;
  assign locked    = r_locked;
  assign bit_valid = r_bit_valid;
  assign bit_out   = r_bit_out;
  assign bit_hist  = r_bit_hist;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_seg_trace_decoder.sv
// Scoreboard bench for seg_trace_decoder: a behavioural model predicts each
// strobe's outputs, which are queued and compared one cycle later.
module tb_seg_trace_decoder;

  logic       clock;
  logic       reset;
  logic       sample;
  logic [6:0] seg_in;
  logic [2:0] digit;
  logic       locked;
  logic       bit_valid;
  logic       bit_out;
  logic [7:0] bit_hist;
  logic       err_pulse;
  logic [7:0] err_count;

  seg_trace_decoder #(.HIST_W(8), .ERR_W(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .sample   (sample),
    .seg_in   (seg_in),
    .digit    (digit),
    .locked   (locked),
    .bit_valid(bit_valid),
    .bit_out  (bit_out),
    .bit_hist (bit_hist),
    .err_pulse(err_pulse),
    .err_count(err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] digit;
    logic       locked;
    logic       bv;
    logic       bo;
    logic [7:0] hist;
    logic       ep;
    logic [7:0] ec;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks;
  int   n_fails;

  logic [6:0] seg_tab [6];
  int         s1_tab  [6];

  // model state
  logic [2:0] m_digit;
  logic       m_locked;
  logic       m_bo;
  logic [7:0] m_hist;
  logic [7:0] m_ec;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_digit = 3'd0; m_locked = 1'b0; m_bo = 1'b0; m_hist = 8'h00; m_ec = 8'h00;
  endtask

  task automatic model_err();
    if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
  endtask

  task automatic model_step(input logic [6:0] seg, output exp_t e);
    int  d;
    int  nxt0;
    int  nxt1;
    d = -1;
    for (int i = 0; i < 6; i++) if (seg_tab[i] == seg) d = i;
    e.bv = 1'b0;
    e.ep = 1'b0;
    if (!m_locked) begin
      if (d >= 0) begin
        m_digit = d[2:0]; m_locked = 1'b1;
      end else begin
        e.ep = 1'b1; model_err();
      end
    end else begin
      nxt0 = (int'(m_digit) + 1) % 6;
      nxt1 = s1_tab[m_digit];
      if (d < 0) begin
        e.ep = 1'b1; model_err(); m_locked = 1'b0;
      end else if (d == nxt0 || d == nxt1) begin
        m_bo = (d == nxt1);
        m_hist = {m_hist[6:0], m_bo};
        e.bv = 1'b1;
        m_digit = d[2:0];
      end else begin
        e.ep = 1'b1; model_err(); m_digit = d[2:0];
      end
    end
    e.digit = m_digit; e.locked = m_locked; e.bo = m_bo; e.hist = m_hist; e.ec = m_ec;
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk_val("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    chk_val("digit",     {29'd0, digit},     {29'd0, e.digit});
    chk_val("locked",    {31'd0, locked},    {31'd0, e.locked});
    chk_val("bit_valid", {31'd0, bit_valid}, {31'd0, e.bv});
    chk_val("bit_out",   {31'd0, bit_out},   {31'd0, e.bo});
    chk_val("bit_hist",  {24'd0, bit_hist},  {24'd0, e.hist});
    chk_val("err_pulse", {31'd0, err_pulse}, {31'd0, e.ep});
    chk_val("err_count", {24'd0, err_count}, {24'd0, e.ec});
  endtask

  // Drive one strobe (back-to-back when called consecutively) and check its result.
  task automatic strobe(input logic [6:0] seg);
    exp_t e;
    sample = 1'b1;
    seg_in = seg;
    model_step(seg, e);
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    compare_out();
  endtask

  task automatic strobe_digit(input int d);
    strobe(seg_tab[d]);
  endtask

  task automatic idle(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      sample = 1'b0;
      seg_in = 7'h7F;
      e.digit = m_digit; e.locked = m_locked; e.bv = 1'b0; e.bo = m_bo;
      e.hist = m_hist; e.ep = 1'b0; e.ec = m_ec;
      sb_q.push_back(e);
      @(posedge clock);
      #1;
      compare_out();
    end
  endtask

  task automatic do_reset();
    sample = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    #2;
    idle_reset_check();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_reset_check();
    chk_val("rst_digit",  {29'd0, digit},     32'd0);
    chk_val("rst_locked", {31'd0, locked},    32'd0);
    chk_val("rst_bv",     {31'd0, bit_valid}, 32'd0);
    chk_val("rst_bo",     {31'd0, bit_out},   32'd0);
    chk_val("rst_hist",   {24'd0, bit_hist},  32'd0);
    chk_val("rst_ep",     {31'd0, err_pulse}, 32'd0);
    chk_val("rst_ec",     {24'd0, err_count}, 32'd0);
  endtask

  initial begin
    int seq_a [7];
    int seq_b [7];
    int seq_c [6];
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    s1_tab[0] = 3; s1_tab[1] = 5; s1_tab[2] = 0; s1_tab[3] = 1; s1_tab[4] = 2; s1_tab[5] = 4;
    seq_a = '{0, 1, 2, 3, 4, 5, 0};
    seq_b = '{0, 3, 1, 5, 4, 2, 0};
    seq_c = '{0, 1, 5, 4, 5, 0};
    n_checks = 0;
    n_fails  = 0;
    sample = 1'b0;
    seg_in = 7'h7F;
    reset  = 1'b1;
    model_reset();
    #3;
    do_reset();
    idle(2);

    // in=0 path
    foreach (seq_a[i]) strobe_digit(seq_a[i]);
    chk_val("a_hist",  {24'd0, bit_hist},  32'h00);
    chk_val("a_digit", {29'd0, digit},     32'd0);
    chk_val("a_ec",    {24'd0, err_count}, 32'd0);
    idle(1);

    // in=1 path
    do_reset();
    foreach (seq_b[i]) strobe_digit(seq_b[i]);
    chk_val("b_hist",  {24'd0, bit_hist}, 32'h3F);
    chk_val("b_digit", {29'd0, digit},    32'd0);

    // mixed
    do_reset();
    foreach (seq_c[i]) strobe_digit(seq_c[i]);
    chk_val("c_hist", {24'd0, bit_hist}, 32'h0C);
    idle(1);

    // illegal steps
    do_reset();
    strobe_digit(2);
    strobe_digit(4);
    chk_val("ill_ec",     {24'd0, err_count}, 32'd1);
    chk_val("ill_digit",  {29'd0, digit},     32'd4);
    chk_val("ill_locked", {31'd0, locked},    32'd1);
    strobe_digit(5);
    chk_val("ill_bit", {30'd0, bit_valid, bit_out}, 32'b10);
    strobe_digit(5);
    chk_val("same_err", {31'd0, err_pulse}, 32'd1);

    // invalid code while locked, then relock and saturation
    strobe(7'b1111111);
    chk_val("inv_locked", {31'd0, locked}, 32'd0);
    chk_val("inv_digit",  {29'd0, digit},  32'd5);
    strobe_digit(0);
    chk_val("relock_bv", {31'd0, bit_valid}, 32'd0);
    for (int i = 0; i < 300; i++) strobe(7'b1111111);
    chk_val("sat_ec", {24'd0, err_count}, 32'd255);
    idle(1);

    // reset mid-stream
    do_reset();
    strobe_digit(3);
    strobe_digit(4);
    sample = 1'b0;
    @(negedge clock);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    idle_reset_check();
    @(negedge clock);
    reset = 1'b1;
    strobe_digit(5);
    chk_val("post_rst_bv",     {31'd0, bit_valid}, 32'd0);
    chk_val("post_rst_locked", {31'd0, locked},    32'd1);
    strobe_digit(0);
    idle(2);

    chk_val("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
